// File: rtl/opp_pkt_pkg.sv
// Shared definitions for the opponent-state packet: frame geometry, field layout,
// reset positions and the receiver state type. The TX encoder imports this too.
package opp_pkt_pkg;

    localparam int FRAME_LEN     = 7;
    localparam int PAYLOAD_BYTES = 5;
    localparam int PAYLOAD_W     = 40;

    localparam int X_W    = 11;
    localparam int Y_W    = 11;
    localparam int DIR_W  = 9;
    localparam int GAME_W = 3;
    localparam int SEQ_W  = 6;

    // Payload is big-endian {x, y, dir, game, seq}; offsets are LSB positions.
    localparam int SEQ_OFF  = 0;
    localparam int GAME_OFF = SEQ_OFF + SEQ_W;
    localparam int DIR_OFF  = GAME_OFF + GAME_W;
    localparam int Y_OFF    = DIR_OFF + DIR_W;
    localparam int X_OFF    = Y_OFF + Y_W;

    localparam logic [7:0]       MAGIC_DEFAULT = 8'hA5;
    localparam logic [X_W-1:0]   RST_X         = 11'd300;
    localparam logic [Y_W-1:0]   RST_Y         = 11'd100;
    localparam logic [DIR_W-1:0] RST_DIR       = 9'd90;
    localparam logic [DIR_W-1:0] DIR_LIMIT     = 9'd360;
    localparam logic [SEQ_W-1:0] RST_SEQ       = 6'h3F;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HDR,
        RX_PAYLOAD,
        RX_CHK,
        RX_DONE,
        RX_DRAIN
    } rx_state_t;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DIR_W-1:0]  dir;
        logic [GAME_W-1:0] game;
    } opp_state_t;

    localparam opp_state_t OPP_RST_STATE = '{x: RST_X, y: RST_Y, dir: RST_DIR, game: '0};

    function automatic opp_state_t unpack_payload(input logic [PAYLOAD_W-1:0] p);
        opp_state_t s;
        s.x    = p[X_OFF    +: X_W];
        s.y    = p[Y_OFF    +: Y_W];
        s.dir  = p[DIR_OFF  +: DIR_W];
        s.game = p[GAME_OFF +: GAME_W];
        return s;
    endfunction

endpackage

// File: rtl/opp_packet_rx_if.sv
// Byte stream feeding the opponent packet decoder.
// axiiv marks a valid byte on axiid; a frame is one unbroken high run and the
// first low cycle ends it. There is no backpressure: the receiver accepts every byte.
interface opp_rx_if;
    logic       axiiv;
    logic [7:0] axiid;

    modport master (output axiiv, output axiid);
    modport slave  (input  axiiv, input  axiid);
endinterface

// File: rtl/opp_packet_rx_link_watchdog.sv
// Loadable down-counter: kick reloads TIMEOUT_CYCLES, alive is high while nonzero.
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic alive
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A kick on the same cycle the count reaches zero still reloads.
    always_comb begin
        cnt_d = cnt_q;
        if (kick) begin
            cnt_d = CW'(TIMEOUT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign alive = (cnt_q != '0);

endmodule

// File: rtl/opp_packet_rx.sv
// Frames, checks and unpacks 7-byte opponent packets into registered game state.
// Define OPP_RX_SEQ_CHECK_EN to silently drop valid frames repeating the last seq.
module opp_packet_rx
    import opp_pkt_pkg::*;
#(
    parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2_500_000
) (
    input  logic             clk,
    input  logic             rst,
    opp_rx_if.slave          rx,
    output logic [X_W-1:0]   r_opp_x,
    output logic [Y_W-1:0]   r_opp_y,
    output logic [DIR_W-1:0] r_opp_dir,
    output logic [GAME_W-1:0] r_opp_game,
    output logic             receive_axiov,
    output logic [7:0]       err_count,
    output logic             link_up,
    output rx_state_t        dbg_state,
    output logic [SEQ_W-1:0] dbg_last_seq
);

    rx_state_t              state_q, state_d;
    logic [PAYLOAD_W-1:0]   shift_q, shift_d;
    logic [7:0]             xor_q, xor_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   chk_ok_q, chk_ok_d;
    opp_state_t             opp_q, opp_d;
    logic                   strobe_q, strobe_d;
    logic [7:0]             err_q, err_d;
    logic [SEQ_W-1:0]       last_seq_q, last_seq_d;

    logic                   kick;
    logic                   frame_end;
    logic                   frame_good;
    logic                   seq_fresh;
    opp_state_t             rx_fields;
    logic [SEQ_W-1:0]       rx_seq;

    assign rx_fields  = unpack_payload(shift_q);
    assign rx_seq     = shift_q[SEQ_OFF +: SEQ_W];
    assign frame_good = (state_q == RX_DONE) && chk_ok_q && (rx_fields.dir < DIR_LIMIT);

`ifdef OPP_RX_SEQ_CHECK_EN
    assign seq_fresh = (rx_seq != last_seq_q);
`else
    assign seq_fresh = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        xor_d      = xor_q;
        cnt_d      = cnt_q;
        chk_ok_d   = chk_ok_q;
        opp_d      = opp_q;
        strobe_d   = 1'b0;
        err_d      = err_q;
        last_seq_d = last_seq_q;
        kick       = 1'b0;
        frame_end  = 1'b0;

        // IDLE consumes B0; HDR/PAYLOAD consume B1..B5; CHK consumes B6.
        case (state_q)
            RX_IDLE: begin
                if (rx.axiiv) begin
                    xor_d    = rx.axiid;
                    cnt_d    = '0;
                    chk_ok_d = 1'b0;
                    state_d  = (rx.axiid == MAGIC) ? RX_HDR : RX_DRAIN;
                end
            end
            RX_HDR, RX_PAYLOAD: begin
                if (rx.axiiv) begin
                    shift_d = {shift_q[PAYLOAD_W-9:0], rx.axiid};
                    xor_d   = xor_q ^ rx.axiid;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'(PAYLOAD_BYTES - 1)) ? RX_CHK : RX_PAYLOAD;
                end else begin
                    frame_end = 1'b1;
                end
            end
            RX_CHK: begin
                if (rx.axiiv) begin
                    chk_ok_d = (rx.axiid == xor_q);
                    state_d  = RX_DONE;
                end else begin
                    frame_end = 1'b1;
                end
            end
            RX_DONE: begin
                if (rx.axiiv) begin
                    state_d = RX_DRAIN;
                end else begin
                    frame_end = 1'b1;
                end
            end
            RX_DRAIN: begin
                if (!rx.axiiv) begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Every non-idle frame is judged exactly once, on its first low cycle.
        if (frame_end) begin
            state_d = RX_IDLE;
            if (frame_good) begin
                kick = 1'b1;
                if (seq_fresh) begin
                    opp_d      = rx_fields;
                    strobe_d   = 1'b1;
                    last_seq_d = rx_seq;
                end
            end else if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            shift_q    <= '0;
            xor_q      <= '0;
            cnt_q      <= '0;
            chk_ok_q   <= 1'b0;
            opp_q      <= OPP_RST_STATE;
            strobe_q   <= 1'b0;
            err_q      <= '0;
            last_seq_q <= RST_SEQ;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            xor_q      <= xor_d;
            cnt_q      <= cnt_d;
            chk_ok_q   <= chk_ok_d;
            opp_q      <= opp_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            last_seq_q <= last_seq_d;
        end
    end

    link_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .kick (kick),
        .alive(link_up)
    );

    assign r_opp_x       = opp_q.x;
    assign r_opp_y       = opp_q.y;
    assign r_opp_dir     = opp_q.dir;
    assign r_opp_game    = opp_q.game;
    assign receive_axiov = strobe_q;
    assign err_count     = err_q;
    assign dbg_state     = state_q;
    assign dbg_last_seq  = last_seq_q;

endmodule

// File: tb/tb_opp_packet_rx.sv
// Bench for opp_packet_rx: directed frames, random frames against a frame-level
// acceptance model, watchdog timing, mid-frame reset and error saturation.
module tb_opp_packet_rx;
    import opp_pkt_pkg::*;

    localparam int         TIMEOUT = 100;
    localparam logic [7:0] MAGIC_B = 8'hA5;
`ifdef OPP_RX_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] r_opp_x, r_opp_y;
    logic [8:0]  r_opp_dir;
    logic [2:0]  r_opp_game;
    logic        receive_axiov;
    logic [7:0]  err_count;
    logic        link_up;
    rx_state_t   dbg_state;
    logic [5:0]  dbg_last_seq;

    opp_rx_if rx_bus ();

    opp_packet_rx #(.MAGIC(MAGIC_B), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx_bus),
        .r_opp_x      (r_opp_x),
        .r_opp_y      (r_opp_y),
        .r_opp_dir    (r_opp_dir),
        .r_opp_game   (r_opp_game),
        .receive_axiov(receive_axiov),
        .err_count    (err_count),
        .link_up      (link_up),
        .dbg_state    (dbg_state),
        .dbg_last_seq (dbg_last_seq)
    );

    // Clock, cycle counter and strobe monitor
    always #5 clk = ~clk;

    int cyc = 0;
    int strobe_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (receive_axiov) strobe_seen <= strobe_seen + 1;

    // Reference model state
    int          n_asserts = 0;
    int          n_fail = 0;
    logic [7:0]  frm_q[$];
    logic [10:0] exp_x, exp_y;
    logic [8:0]  exp_dir;
    logic [2:0]  exp_game;
    logic [7:0]  exp_err;
    logic [5:0]  exp_last_seq;
    bit          exp_strobe;
    int          exp_strobes = 0;
    bit          have_kick;
    int          kick_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_link();
        return have_kick && ((cyc - kick_cyc) < TIMEOUT);
    endfunction

    task automatic model_reset();
        exp_x = 11'd300; exp_y = 11'd100; exp_dir = 9'd90; exp_game = 3'd0;
        exp_err = 8'd0; exp_last_seq = 6'h3F; exp_strobe = 1'b0; have_kick = 1'b0;
        kick_cyc = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".x"},      32'(r_opp_x),       32'(exp_x));
        chk({tag, ".y"},      32'(r_opp_y),       32'(exp_y));
        chk({tag, ".dir"},    32'(r_opp_dir),     32'(exp_dir));
        chk({tag, ".game"},   32'(r_opp_game),    32'(exp_game));
        chk({tag, ".strobe"}, 32'(receive_axiov), 32'(exp_strobe));
        chk({tag, ".err"},    32'(err_count),     32'(exp_err));
        chk({tag, ".link"},   32'(link_up),       32'(exp_link()));
        chk({tag, ".state"},  32'(dbg_state),     32'(RX_IDLE));
        chk({tag, ".seq"},    32'(dbg_last_seq),  32'(exp_last_seq));
    endtask

    task automatic build_frame(input logic [10:0] x, input logic [10:0] y, input logic [8:0] dir,
                               input logic [2:0] game, input logic [5:0] seq);
        logic [39:0] p;
        logic [7:0]  cs;
        p = {x, y, dir, game, seq};
        frm_q = {};
        frm_q.push_back(MAGIC_B);
        for (int i = 4; i >= 0; i--) frm_q.push_back(p[i*8 +: 8]);
        cs = '0;
        for (int i = 0; i < 6; i++) cs ^= frm_q[i];
        frm_q.push_back(cs);
    endtask

    // Driver: sends frm_q back-to-back from the current cycle, then one low cycle,
    // then updates the model and checks. Entered and left at posedge+1.
    task automatic run_frame(input string tag);
        int          n;
        logic [39:0] p;
        logic [7:0]  cs;
        bit          acc;
        bit          fresh;
        n = frm_q.size();
        acc = 1'b0;
        p = '0;
        if (n == 7) begin
            p = {frm_q[1], frm_q[2], frm_q[3], frm_q[4], frm_q[5]};
            cs = '0;
            for (int i = 0; i < 6; i++) cs ^= frm_q[i];
            acc = (frm_q[0] == MAGIC_B) && (cs == frm_q[6]) && (p[17:9] < 9'd360);
        end
        fresh = acc && !(SEQ_EN && (p[5:0] == exp_last_seq));
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            rx_bus.axiiv = 1'b1;
            rx_bus.axiid = frm_q[i];
        end
        @(posedge clk); #1;
        rx_bus.axiiv = 1'b0;
        rx_bus.axiid = 8'($urandom);
        @(posedge clk); #1;
        if (acc) begin
            have_kick = 1'b1;
            kick_cyc = cyc;
        end
        exp_strobe = fresh;
        if (fresh) begin
            exp_x = p[39:29]; exp_y = p[28:18]; exp_dir = p[17:9]; exp_game = p[8:6];
            exp_last_seq = p[5:0];
            exp_strobes++;
        end
        if (!acc && exp_err != 8'hFF) exp_err++;
        check_outputs(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
        exp_strobe = 1'b0;
    endtask

    initial begin
        logic [10:0] rx_x, rx_y;
        logic [8:0]  rdir;
        logic [2:0]  rgame;
        logic [5:0]  rseq;
        int          mode;
        int          len;

        rx_bus.axiiv = 1'b0;
        rx_bus.axiid = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_outputs("reset");

        // Directed frame from the test plan, with absolute expectations
        frm_q = {8'hA5, 8'h25, 8'h81, 8'h90, 8'hB4, 8'h45, 8'h60};
        run_frame("valid");
        chk("valid.abs_x", 32'(r_opp_x), 32'd300);
        chk("valid.abs_game", 32'(r_opp_game), 32'd1);
        chk("valid.abs_strobe", 32'(receive_axiov), 32'd1);
        chk("valid.abs_link", 32'(link_up), 32'd1);

        frm_q = {8'hA5, 8'h25, 8'h81, 8'h90, 8'hB4, 8'h45, 8'h61};
        run_frame("bad_chk");
        chk("bad_chk.abs_err", 32'(err_count), 32'd1);

        frm_q = {8'hA4, 8'h25, 8'h81, 8'h90, 8'hB4, 8'h45, 8'h60};
        run_frame("bad_magic");
        frm_q = {8'hA5, 8'h25, 8'h81, 8'h90, 8'hB4, 8'h45, 8'h60, 8'h00};
        run_frame("overlong");
        frm_q = {8'hA5, 8'h25, 8'h81, 8'h90};
        run_frame("runt4");
        chk("runt4.abs_err", 32'(err_count), 32'd4);

        build_frame(11'd1234, 11'd777, 9'd359, 3'd5, 6'd9);
        run_frame("dup_a");
        build_frame(11'd1234, 11'd777, 9'd359, 3'd5, 6'd9);
        run_frame("dup_b");
        chk("dup_b.strobe_abs", 32'(receive_axiov), SEQ_EN ? 32'd0 : 32'd1);

        // Watchdog: link stays up through 99 cycles, drops at 100
        idle(TIMEOUT - 1);
        chk("wd_99", 32'(link_up), 32'd1);
        idle(1);
        chk("wd_100", 32'(link_up), 32'd0);
        chk("wd_hold_x", 32'(r_opp_x), 32'(exp_x));

        // Random frames against the model
        for (int k = 0; k < 60; k++) begin
            rx_x = 11'($urandom); rx_y = 11'($urandom);
            rdir = 9'($urandom_range(0, 359)); rgame = 3'($urandom);
            rseq = 6'($urandom_range(0, 3));
            mode = $urandom_range(0, 8);
            if (mode == 5) rdir = 9'($urandom_range(360, 511));
            build_frame(rx_x, rx_y, rdir, rgame, rseq);
            case (mode)
                3: frm_q[6] = frm_q[6] ^ 8'($urandom_range(1, 255));
                4: frm_q[0] = frm_q[0] ^ 8'($urandom_range(1, 255));
                6: begin
                    len = $urandom_range(1, 6);
                    while (frm_q.size() > len) void'(frm_q.pop_back());
                end
                7: repeat ($urandom_range(1, 3)) frm_q.push_back(8'($urandom));
                default: ;
            endcase
            run_frame("rand");
        end

        // Reset in the middle of a frame discards it without an error count
        build_frame(11'd5, 11'd6, 9'd7, 3'd2, 6'd33);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            rx_bus.axiiv = 1'b1;
            rx_bus.axiid = frm_q[i];
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rx_bus.axiiv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_outputs("midrst");
        run_frame("after_rst");
        chk("after_rst.abs_strobe", 32'(receive_axiov), 32'd1);

        // Saturation of the error counter
        for (int k = 0; k < 260; k++) begin
            frm_q = {8'($urandom_range(0, 8'hA4))};
            run_frame("sat");
        end
        chk("sat.abs_err", 32'(err_count), 32'd255);

        idle(2);
        chk("strobe_total", 32'(strobe_seen), 32'(exp_strobes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
